posit_construction: RTL and testbench
=====================================

POSIT_CONSTRUCTION -- requirements
Module: posit_construction

Interface
REQ-001 Parameter N, default 8: posit word width in bits.
REQ-002 Parameter ES, default 3: exponent field width in bits.
REQ-003 Parameter RS, default $clog2(N): regime-count width; the regime input is RS+2 bits signed.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port in_valid, input, 1: input fields valid.
REQ-008 Port in_ready, output, 1: block accepts input this cycle.
REQ-009 Port Sign, input, 1: sign of the value.
REQ-010 Port RegimeValue, input, RS+2 signed: regime k.
REQ-011 Port Exponent, input, ES: unsigned exponent.
REQ-012 Port Mantissa, input, N-ES+3: bit [N-ES+2] is the hidden 1 and is ignored; bits [N-ES+1:0] are the fraction, MSB first.
REQ-013 Port IsZero, input, 1: encode zero; overrides all other fields.
REQ-014 Port IsNaR, input, 1: encode NaR; overrides IsZero and all other fields.
REQ-015 Port out_valid, output, 1: Posit is valid.
REQ-016 Port out_ready, input, 1: downstream accepts Posit.
REQ-017 Port Posit, output, N: encoded posit.

Function
REQ-018 The block SHALL be a two-stage elastic pipeline; a transfer occurs on a clk edge where valid and ready are both 1 on that interface.
REQ-019 Stage 1 SHALL register the fields and form the unrounded magnitude string: sign bit excluded; regime of (k+1) ones then a 0 for k>=0, or (-k) zeros then a 1 for k<0; then Exponent; then fraction.
REQ-020 Stage 2 SHALL take the top N-1 bits of the string as the magnitude. Guard is the next bit; sticky is the OR of all remaining bits.
REQ-021 Stage 2 SHALL round to nearest, ties to even: increment when guard & (sticky | LSB).
REQ-022 The magnitude SHALL saturate. Clamp to maxpos (N-1 ones) for k>=N-2 or on rounding overflow. Clamp to minpos (1) when the magnitude would be 0, including k<=-(N-1).
REQ-023 When Sign=1, Posit SHALL be the two's complement of {1'b0, magnitude}; otherwise Posit SHALL be {1'b0, magnitude}.
REQ-024 IsNaR SHALL yield a 1 followed by N-1 zeros; IsZero alone SHALL yield all zeros. Neither case is rounded or saturated.
REQ-025 Latency SHALL be exactly 2 cycles from the input transfer to out_valid=1 when out_ready stays 1; throughput SHALL be one result per cycle.
REQ-026 in_ready SHALL be (stage-1 empty) OR (stage 1 advancing this cycle); stage 1 advances when stage 2 is empty or out_ready=1.
REQ-027 While out_valid=1 and out_ready=0, Posit SHALL hold stable and no stage SHALL advance or drop data.
REQ-028 A simultaneous input transfer and output transfer on a full pipe SHALL lose no item and duplicate no item.
REQ-029 Results SHALL leave in acceptance order.

Reset
REQ-030 While reset=1: out_valid=0, Posit=0, in_ready=0, and both stages are empty.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight items; no output SHALL appear for them.
REQ-032 In the first cycle after reset deasserts, in_ready SHALL be 1.

Verification (N=8, ES=3)
REQ-033 k=0, Exponent=0, fraction=0, Sign=0 -> Posit=0x40 two cycles later.
REQ-034 k=1, Exponent=3, fraction MSB=1, rest 0 -> 0x67; the same value with Sign=1 -> 0x99.
REQ-035 k=0, Exponent=0, fraction=0b011000... -> 0x42 (tie, odd LSB rounds up); fraction=0b001000... -> 0x40 (tie, even LSB holds).
REQ-036 k=7 -> 0x7F; k=-7 -> 0x01; IsNaR=1 -> 0x80; IsZero=1 -> 0x00.
REQ-037 Stream 4 items with out_ready=0 for 3 cycles -> in_ready falls after 2 items are accepted; on release all 4 results emerge in order, none lost or duplicated, and Posit stays stable while stalled.
REQ-038 Assert reset with 2 items in flight -> out_valid=0 next cycle, and neither item is ever output.

Source files
------------

// File: rtl/posit_construction_if.sv
// posit_construction_if: handshake bundle for the posit construction block.
// Input side : in_valid/in_ready with Sign, RegimeValue (k), Exponent,
//              Mantissa (hidden bit + fraction), IsZero, IsNaR.
// Output side: out_valid/out_ready with the encoded Posit word.
// Modports   : slave  - the encoder (consumes fields, produces Posit)
//              master - the environment driving fields and taking Posit
interface posit_construction_if #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 Sign;
  logic signed [RS+1:0] RegimeValue;
  logic [ES-1:0]        Exponent;
  logic [N-ES+2:0]      Mantissa;
  logic                 IsZero;
  logic                 IsNaR;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         Posit;

  modport slave (
    input  in_valid, Sign, RegimeValue, Exponent, Mantissa, IsZero, IsNaR,
    input  out_ready,
    output in_ready, out_valid, Posit
  );

  modport master (
    output in_valid, Sign, RegimeValue, Exponent, Mantissa, IsZero, IsNaR,
    output out_ready,
    input  in_ready, out_valid, Posit
  );
endinterface

// File: rtl/posit_construction.sv
// posit_construction: two-stage elastic pipeline that packs sign, regime k,
// exponent and fraction into an N-bit posit with round-to-nearest-even and
// saturation to minpos/maxpos. NaR and zero are encoded directly.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset (empties both stages)
//   bus   - posit_construction_if.slave: input fields + valid/ready,
//           Posit + valid/ready on the output side
module posit_construction #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  posit_construction_if.slave    bus
);
  // Magnitude string: longest in-range regime (N-1 bits) + exponent + fraction.
  localparam int W  = 2*N + 1;
  localparam int FW = N - ES + 2;
  localparam logic signed [RS+1:0] K_HI = (RS+2)'(N-2);
  localparam logic signed [RS+1:0] K_LO = (RS+2)'(-(N-1));

  // Regime run/terminator followed by {exponent, fraction}. Only meaningful
  // for K_LO < k < K_HI; outside that range saturation overrides the result.
  function automatic logic [W-1:0] build_str(input logic signed [RS+1:0] k,
                                             input logic [ES-1:0] e,
                                             input logic [FW-1:0] f);
    logic [RS+1:0] kk;
    logic [RS+1:0] sh;
    logic [N-2:0]  pre;
    logic [N+1:0]  rem;
    rem = {e, f};
    if (!k[RS+1]) begin
      kk  = k;
      pre = ~({(N-1){1'b1}} >> (kk + (RS+2)'(1)));
      sh  = (RS+2)'(N-3) - kk;
    end else begin
      kk  = -k;
      pre = {1'b1, {(N-2){1'b0}}} >> kk;
      sh  = (RS+2)'(N-2) - kk;
    end
    return {pre, {(N+2){1'b0}}} | ({{(N-1){1'b0}}, rem} << sh);
  endfunction

  function automatic logic [N-2:0] round_sat(input logic [W-1:0] s,
                                             input logic hi,
                                             input logic lo);
    logic [N-2:0] mag;
    logic         g;
    logic         st;
    logic [N-1:0] sum;
    mag = s[W-1 -: N-1];
    g   = s[W-N];
    st  = |s[W-N-1:0];
    sum = {1'b0, mag} + {{(N-1){1'b0}}, g & (st | mag[0])};
    if (hi || sum[N-1]) return {(N-1){1'b1}};
    if (lo || sum == '0) return (N-1)'(1);
    return sum[N-2:0];
  endfunction

  function automatic logic [N-1:0] encode(input logic sgn, input logic zero,
                                          input logic nar, input logic [N-2:0] mag);
    if (nar)  return {1'b1, {(N-1){1'b0}}};
    if (zero) return '0;
    if (sgn)  return -{1'b0, mag};
    return {1'b0, mag};
  endfunction

  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  logic [W-1:0] str_p1_q;
  logic sign_p1_q, zero_p1_q, nar_p1_q, hi_p1_q, lo_p1_q;
  logic [N-1:0] posit_p2_q;
  logic adv_p2, in_fire;
  logic unused_hidden;

  assign unused_hidden = bus.Mantissa[N-ES+2];

  assign adv_p2       = !vld_p2_q || bus.out_ready;
  assign bus.in_ready = !reset && (!vld_p1_q || adv_p2);
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld_p2_q && !reset;
  assign bus.Posit     = reset ? '0 : posit_p2_q;

  always_comb begin
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    if (adv_p2)       vld_p2_d = vld_p1_q;
    if (bus.in_ready) vld_p1_d = bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // ---- stage 1: capture fields, form unrounded magnitude string ----
  always_ff @(posedge clk) begin
    if (in_fire) begin
      str_p1_q  <= build_str(bus.RegimeValue, bus.Exponent, bus.Mantissa[FW-1:0]);
      sign_p1_q <= bus.Sign;
      zero_p1_q <= bus.IsZero;
      nar_p1_q  <= bus.IsNaR;
      hi_p1_q   <= bus.RegimeValue >= K_HI;
      lo_p1_q   <= bus.RegimeValue <= K_LO;
    end
  end

  // ---- stage 2: round, saturate, apply sign ----
  always_ff @(posedge clk) begin
    if (vld_p1_q && adv_p2) begin
      posit_p2_q <= encode(sign_p1_q, zero_p1_q, nar_p1_q,
                           round_sat(str_p1_q, hi_p1_q, lo_p1_q));
    end
  end
endmodule

// File: tb/tb_posit_construction.sv
module tb_posit_construction;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  posit_construction_if #(.N(8), .ES(3)) bus ();

  posit_construction #(.N(8), .ES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input int k, input logic [2:0] e,
                       input logic [6:0] f, input logic z, input logic nr);
    bus.in_valid    = 1'b1;
    bus.Sign        = s;
    bus.RegimeValue = k[4:0];
    bus.Exponent    = e;
    bus.Mantissa    = {1'b1, f};
    bus.IsZero      = z;
    bus.IsNaR       = nr;
  endtask

  // Single item with out_ready=1: not valid after one edge, valid after two.
  task automatic vec(input string tag, input logic s, input int k, input logic [2:0] e,
                     input logic [6:0] f, input logic z, input logic nr,
                     input logic [7:0] exp);
    drive(s, k, e, f, z, nr);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_lat1"}, {7'd0, bus.out_valid}, 8'h00);
    @(negedge clk);
    check({tag, "_vld"}, {7'd0, bus.out_valid}, 8'h01);
    check(tag, bus.Posit, exp);
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 0, 3'd0, 7'd0, 1'b0, 1'b0);
    bus.in_valid  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {7'd0, bus.out_valid}, 8'h00);
    check("rst_in_ready",  {7'd0, bus.in_ready},  8'h00);
    check("rst_posit",     bus.Posit,             8'h00);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {7'd0, bus.in_ready}, 8'h01);
    @(negedge clk);

    vec("k0",        1'b0,  0, 3'd0, 7'b0000000, 1'b0, 1'b0, 8'h40);
    vec("k1e3",      1'b0,  1, 3'd3, 7'b1000000, 1'b0, 1'b0, 8'h67);
    vec("k1e3_neg",  1'b1,  1, 3'd3, 7'b1000000, 1'b0, 1'b0, 8'h99);
    vec("tie_odd",   1'b0,  0, 3'd0, 7'b0110000, 1'b0, 1'b0, 8'h42);
    vec("tie_even",  1'b0,  0, 3'd0, 7'b0010000, 1'b0, 1'b0, 8'h40);
    vec("kmax",      1'b0,  7, 3'd0, 7'b0000000, 1'b0, 1'b0, 8'h7F);
    vec("kmin",      1'b0, -7, 3'd0, 7'b0000000, 1'b0, 1'b0, 8'h01);
    vec("kmin_neg",  1'b1, -7, 3'd0, 7'b0000000, 1'b0, 1'b0, 8'hFF);
    vec("km6_rnd",   1'b0, -6, 3'd4, 7'b0000000, 1'b0, 1'b0, 8'h02);
    vec("nar",       1'b0,  2, 3'd5, 7'b1010101, 1'b1, 1'b1, 8'h80);
    vec("zero",      1'b1,  2, 3'd5, 7'b1010101, 1'b1, 1'b0, 8'h00);

    // Stall: four items, downstream blocked for three edges.
    @(negedge clk);
    drive(1'b0, 0, 3'd0, 7'd0, 1'b0, 1'b0);          // A -> 0x40
    @(negedge clk);
    check("stall_rdy_a", {7'd0, bus.in_ready}, 8'h01);
    drive(1'b0, 1, 3'd3, 7'b1000000, 1'b0, 1'b0);    // B -> 0x67
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("stall_rdy_full", {7'd0, bus.in_ready}, 8'h00);
    check("stall_vld",      {7'd0, bus.out_valid}, 8'h01);
    check("stall_posit0",   bus.Posit, 8'h40);
    drive(1'b0, 7, 3'd0, 7'd0, 1'b0, 1'b0);          // C -> 0x7F
    @(negedge clk);
    check("stall_rdy_hold", {7'd0, bus.in_ready}, 8'h00);
    check("stall_posit1",   bus.Posit, 8'h40);
    @(negedge clk);
    check("stall_posit2",   bus.Posit, 8'h40);
    bus.out_ready = 1'b1;
    #1;
    check("release_rdy", {7'd0, bus.in_ready}, 8'h01);
    @(negedge clk);
    check("drain_b", bus.Posit, 8'h67);
    drive(1'b0, -7, 3'd0, 7'd0, 1'b0, 1'b0);         // D -> 0x01
    @(negedge clk);
    check("drain_c", bus.Posit, 8'h7F);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("drain_d_vld", {7'd0, bus.out_valid}, 8'h01);
    check("drain_d", bus.Posit, 8'h01);
    @(negedge clk);
    check("drain_empty", {7'd0, bus.out_valid}, 8'h00);

    // Reset with two items in flight.
    drive(1'b0, 0, 3'd0, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1, 3'd3, 7'b1000000, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_vld", {7'd0, bus.out_valid}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("after_rst_vld", {7'd0, bus.out_valid}, 8'h00);
    check("after_rst_rdy", {7'd0, bus.in_ready}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flushed_vld", {7'd0, bus.out_valid}, 8'h00);
    end

    vec("recover", 1'b1, 0, 3'd0, 7'd0, 1'b0, 1'b0, 8'hC0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
